// File: rtl/instr_encoder_loader_pkg.sv
// Shared codes for the descriptor -> RV32I encoder/loader: op classes, ALU codes,
// error codes, opcodes and funct fields (same values the control decoder uses).
package instr_encoder_loader_pkg;

    localparam logic [2:0] OPC_ARITH = 3'd0;
    localparam logic [2:0] OPC_ADDI  = 3'd1;
    localparam logic [2:0] OPC_COND  = 3'd2;
    localparam logic [2:0] OPC_JAL   = 3'd3;
    localparam logic [2:0] OPC_JALR  = 3'd4;
    localparam logic [2:0] OPC_LOAD  = 3'd5;
    localparam logic [2:0] OPC_STORE = 3'd6;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [6:0] OP_ARITH = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_COND  = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [1:0] {ERR_NONE, ERR_ILLEGAL, ERR_RANGE, ERR_OVF} err_e;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J} fmt_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

endpackage

// File: rtl/instr_encoder_loader_imm_pack.sv
// Places a signed byte offset into the immediate bit positions of an RV32I format
// and reports whether it is representable in that format.
module rv_imm_pack
    import instr_encoder_loader_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [20:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_ok
);

    always_comb begin
        imm_bits = '0;
        range_ok = 1'b1;
        case (fmt)
            FMT_I: begin
                imm_bits[31:20] = imm[11:0];
                range_ok        = (&imm[20:11]) | ~(|imm[20:11]);
            end
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                range_ok        = (&imm[20:11]) | ~(|imm[20:11]);
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                range_ok        = ((&imm[20:12]) | ~(|imm[20:12])) & ~imm[0];
            end
            FMT_J: begin
                // the 21-bit input already spans the full J range; only parity matters
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                range_ok        = ~imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes operation descriptors into RV32I words and streams them into imem,
// one per cycle, with session control, write counting and a first-error latch.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_alu,
    input  logic              in_bne,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   wr_count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(DEPTH - 1);

    state_e      state, state_nxt;
    fmt_e        fmt;
    err_e        err_in, err_q;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        use_rd, use_rs1, use_rs2, illegal, range_ok;
    logic [31:0] imm_bits, word;
    logic        accept, do_write, last_slot, open;

    rv_imm_pack u_imm_pack (
        .fmt      (fmt),
        .imm      (in_imm),
        .imm_bits (imm_bits),
        .range_ok (range_ok)
    );

    always_comb begin
        fmt     = FMT_R;
        opcode  = '0;
        f3      = '0;
        f7      = '0;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        illegal = 1'b0;
        case (in_op)
            OPC_ARITH: begin
                opcode  = OP_ARITH;
                use_rs2 = 1'b1;
                case (in_alu)
                    ALU_ADD: f3 = F3_ADD;
                    ALU_SUB: begin f3 = F3_ADD; f7 = F7_SUB; end
                    ALU_AND: f3 = F3_AND;
                    ALU_OR:  f3 = F3_OR;
                    ALU_XOR: f3 = F3_XOR;
                    ALU_SLT: f3 = F3_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ADDI:  begin fmt = FMT_I; opcode = OP_IMM; end
            OPC_COND:  begin fmt = FMT_B; opcode = OP_COND; f3 = {2'b00, in_bne}; use_rd = 1'b0; use_rs2 = 1'b1; end
            OPC_JAL:   begin fmt = FMT_J; opcode = OP_JAL; use_rs1 = 1'b0; end
            OPC_JALR:  begin fmt = FMT_I; opcode = OP_JALR; end
            OPC_LOAD:  begin fmt = FMT_I; opcode = OP_LOAD; f3 = F3_LW; end
            OPC_STORE: begin fmt = FMT_S; opcode = OP_STORE; f3 = F3_LW; use_rd = 1'b0; use_rs2 = 1'b1; end
            default:   illegal = 1'b1;
        endcase

        word = imm_bits | {f7, 25'b0} | {17'b0, f3, 5'b0, opcode};
        if (use_rs2) word[24:20] = in_rs2;
        if (use_rs1) word[19:15] = in_rs1;
        if (use_rd)  word[11:7]  = in_rd;

        err_in = illegal ? ERR_ILLEGAL : (range_ok ? ERR_NONE : ERR_RANGE);
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign in_ready  = busy && (wr_count < CNT_DEPTH);
    assign accept    = in_valid && in_ready;
    assign do_write  = accept && (err_in == ERR_NONE);
    assign last_slot = (wr_count == CNT_LAST);
    assign open      = start && !busy;
    assign err_code  = err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (accept && (in_last || (do_write && last_slot))) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            wr_count   <= '0;
            err        <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state   <= state_nxt;
            imem_we <= do_write;
            if (open) begin
                wr_count  <= '0;
                err       <= 1'b0;
                err_q     <= ERR_NONE;
                imem_addr <= BASE;
            end
            if (do_write) begin
                imem_wdata <= word;
                imem_addr  <= BASE + wr_count[ADDR_W-1:0];
                wr_count   <= wr_count + 1'b1;
            end
            // first error wins; overflow only counts when the filling word was not the last
            if (accept && err_q == ERR_NONE) begin
                if (err_in != ERR_NONE) begin
                    err   <= 1'b1;
                    err_q <= err_in;
                end else if (last_slot && !in_last) begin
                    err   <= 1'b1;
                    err_q <= ERR_OVF;
                end
            end
        end
    end

endmodule
